// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, states, byte-enable helpers.
package mem_lsu_pkg;

    localparam int unsigned ALU_OP_W = 8;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned BE_W     = 4;

    typedef logic [ALU_OP_W-1:0] aluop_t;

    localparam logic              RST_ENABLE = 1'b1;
    localparam logic [XLEN-1:0]   ZERO_WORD  = '0;
    localparam logic [REG_AW-1:0] ZERO_REG   = '0;

    // Memory op codes as already used by the execute stage
    localparam aluop_t OP_LB  = 8'h80;
    localparam aluop_t OP_LH  = 8'h81;
    localparam aluop_t OP_LW  = 8'h83;
    localparam aluop_t OP_LBU = 8'h84;
    localparam aluop_t OP_LHU = 8'h85;
    localparam aluop_t OP_SB  = 8'h88;
    localparam aluop_t OP_SH  = 8'h89;
    localparam aluop_t OP_SW  = 8'h8B;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    // Payload held on the data bus for the life of one request
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
        logic            we;
    } dbus_req_t;

    function automatic logic is_load(input aluop_t op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input aluop_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem_op(input aluop_t op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one
    function automatic logic is_aligned(input aluop_t op, input logic [1:0] off);
        logic ok;
        ok = 1'b1;
        if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) ok = (off[0] == 1'b0);
        if ((op == OP_LW) || (op == OP_SW))                   ok = (off == 2'b00);
        return ok;
    endfunction

    function automatic logic [BE_W-1:0] byte_en(input aluop_t op, input logic [1:0] off);
        logic [BE_W-1:0] be;
        case (op)
            OP_SB:   be = BE_BYTE << off;
            OP_SH:   be = BE_HALF << {off[1], 1'b0};
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    // Replicate store data onto every lane so the slave can pick by byte enable
    function automatic logic [XLEN-1:0] store_fmt(input aluop_t op, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (op)
            OP_SB:   w = {4{d[7:0]}};
            OP_SH:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load data alignment: select byte/half lane from the bus word and sign/zero extend.
module mem_lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  aluop_t          op_i,
    output logic [XLEN-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension chosen by the latched op
    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_c   = rdata_i;
        case (op_i)
            OP_LB:   data_c = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_c = {24'b0, byte_sel};
            OP_LH:   data_c = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_c = {16'b0, half_sel};
            default: data_c = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: data-bus master, load alignment, misalign/timeout exceptions, stall.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  aluop_t            aluop_i,
    input  logic [XLEN-1:0]   mem_addr_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [REG_AW-1:0] reg_waddr_i,
    input  logic [XLEN-1:0]   reg_wdata_i,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic [REG_AW-1:0] reg_waddr_o,
    output logic [XLEN-1:0]   reg_wdata_o,
    output logic              exc_misalign_o,
    output logic              exc_fault_o,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [XLEN-1:0]   dbus_addr_o,
    output logic [BE_W-1:0]   dbus_be_o,
    output logic [XLEN-1:0]   dbus_wdata_o,
    input  logic              dbus_gnt_i,
    input  logic              dbus_rvalid_i,
    input  logic [XLEN-1:0]   dbus_rdata_i
);

    // Counter must hold TIMEOUT_CYC itself (a load granted in the expiry cycle steps once more)
    localparam int unsigned      CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e        state_q, state_d;
    dbus_req_t         bus_q, bus_d;
    logic              req_q, req_d;
    aluop_t            op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              exc_mis_q, exc_mis_d;
    logic              exc_fault_q, exc_fault_d;

    logic              in_mem_c;
    logic              in_aligned_c;
    logic              timeout_hit_c;
    logic [XLEN-1:0]   load_data_c;

    mem_lsu_load_align u_load_align (
        .rdata_i (dbus_rdata_i),
        .off_i   (off_q),
        .op_i    (op_q),
        .data_c  (load_data_c)
    );

    // Decode of the incoming entry and timeout expiry
    always_comb begin
        in_mem_c      = is_mem_op(aluop_i);
        in_aligned_c  = is_aligned(aluop_i, mem_addr_i[1:0]);
        timeout_hit_c = (TIMEOUT_CYC != 0) && (cnt_q >= CNT_LAST);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        req_d       = req_q;
        op_d        = op_q;
        off_d       = off_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_mis_d   = 1'b0;
        exc_fault_d = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (req_valid_i) begin
                    if (!in_mem_c) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = reg_waddr_i;
                        wb_data_d  = reg_wdata_i;
                    end else if (!in_aligned_c) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ZERO_REG;
                        wb_data_d  = ZERO_WORD;
                        exc_mis_d  = 1'b1;
                    end else begin
                        state_d     = LSU_REQ;
                        req_d       = 1'b1;
                        bus_d.addr  = {mem_addr_i[XLEN-1:2], 2'b00};
                        bus_d.be    = byte_en(aluop_i, mem_addr_i[1:0]);
                        bus_d.wdata = store_fmt(aluop_i, store_data_i);
                        bus_d.we    = is_store(aluop_i);
                        op_d        = aluop_i;
                        off_d       = mem_addr_i[1:0];
                        rd_d        = reg_waddr_i;
                        cnt_d       = '0;
                    end
                end
            end
            LSU_REQ: begin
                if (dbus_gnt_i) begin
                    req_d = 1'b0;
                    if (bus_q.we) begin
                        state_d    = LSU_IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ZERO_REG;
                        wb_data_d  = ZERO_WORD;
                    end else if (dbus_rvalid_i) begin
                        state_d    = LSU_IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_data_c;
                    end else begin
                        state_d = LSU_WAIT;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else if (timeout_hit_c) begin
                    state_d     = LSU_IDLE;
                    req_d       = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = ZERO_REG;
                    wb_data_d   = ZERO_WORD;
                    exc_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_WAIT: begin
                if (dbus_rvalid_i) begin
                    state_d    = LSU_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_data_c;
                end else if (timeout_hit_c) begin
                    state_d     = LSU_IDLE;
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = ZERO_REG;
                    wb_data_d   = ZERO_WORD;
                    exc_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LSU_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops an in-flight request immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RST_ENABLE) begin
            state_q     <= LSU_IDLE;
            bus_q       <= '0;
            req_q       <= 1'b0;
            op_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_mis_q   <= 1'b0;
            exc_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            req_q       <= req_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_mis_q   <= exc_mis_d;
            exc_fault_q <= exc_fault_d;
        end
    end

    // Output mapping; only ready and stall are combinational
    always_comb begin
        req_ready_o    = (state_q == LSU_IDLE);
        stall_o        = (state_q != LSU_IDLE) |
                         (req_valid_i & in_mem_c & (state_q == LSU_IDLE) & in_aligned_c);
        wb_valid_o     = wb_valid_q;
        reg_waddr_o    = wb_rd_q;
        reg_wdata_o    = wb_data_q;
        exc_misalign_o = exc_mis_q;
        exc_fault_o    = exc_fault_q;
        dbus_req_o     = req_q;
        dbus_we_o      = bus_q.we;
        dbus_addr_o    = bus_q.addr;
        dbus_be_o      = bus_q.be;
        dbus_wdata_o   = bus_q.wdata;
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table, writeback scoreboard, timeout and reset sequences.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int unsigned TO = 8;
    localparam aluop_t TB_OP_ADD = 8'h20;
    localparam int NV = 19;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    aluop_t      aluop_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic [31:0] reg_wdata_i = '0;
    logic        stall_o;
    logic        wb_valid_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        exc_misalign_o;
    logic        exc_fault_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i = 1'b0;
    logic        dbus_rvalid_i = 1'b0;
    logic [31:0] dbus_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    mem_lsu #(.TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
        .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
        .stall_o(stall_o), .wb_valid_o(wb_valid_o),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .exc_misalign_o(exc_misalign_o), .exc_fault_o(exc_fault_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        fault;
    } wb_exp_t;

    typedef struct {
        aluop_t      op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    wb_exp_t sb_q[$];
    vec_t    vecs[NV];
    int      n_checks = 0;
    int      n_fail = 0;
    bit      wb_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and score any writeback produced in the new cycle
    task automatic tick();
        wb_exp_t e;
        @(posedge clk_i);
        #1;
        if (wb_valid_o) begin
            wb_seen = 1'b1;
            if (sb_q.size() == 0) begin
                chk("unexpected_wb", 32'(wb_valid_o), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_rd", 32'(reg_waddr_o), 32'(e.rd));
                chk("wb_data", reg_wdata_o, e.data);
                chk("wb_misalign", 32'(exc_misalign_o), 32'(e.mis));
                chk("wb_fault", 32'(exc_fault_o), 32'(e.fault));
            end
        end else if (exc_misalign_o || exc_fault_o) begin
            chk("exc_without_wb", 32'({exc_misalign_o, exc_fault_o}), 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wb_exp_t e;
        int guard;
        wb_seen      = 1'b0;
        req_valid_i  = 1'b1;
        aluop_i      = v.op;
        mem_addr_i   = v.addr;
        store_data_i = v.sdata;
        reg_waddr_i  = v.rd;
        reg_wdata_i  = v.alu;
        e.rd = v.exp_rd; e.data = v.exp_data; e.mis = v.exp_mis; e.fault = 1'b0;
        sb_q.push_back(e);
        #1;
        chk($sformatf("v%0d_stall_accept", idx), 32'(stall_o), 32'(v.exp_req));
        chk($sformatf("v%0d_ready_idle", idx), 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        if (v.exp_req) begin
            for (int c = 0; c <= v.gnt_dly; c++) begin
                chk($sformatf("v%0d_dbus_req", idx), 32'(dbus_req_o), 32'd1);
                chk($sformatf("v%0d_dbus_addr", idx), dbus_addr_o, v.exp_baddr);
                chk($sformatf("v%0d_dbus_be", idx), 32'(dbus_be_o), 32'(v.exp_be));
                chk($sformatf("v%0d_dbus_we", idx), 32'(dbus_we_o), 32'(v.exp_we));
                if (v.exp_we) chk($sformatf("v%0d_dbus_wdata", idx), dbus_wdata_o, v.exp_bwdata);
                if (c == 0) chk($sformatf("v%0d_stall_busy", idx), 32'(stall_o), 32'd1);
                if (c < v.gnt_dly && !v.exp_we) begin
                    dbus_rvalid_i = 1'b1;
                    dbus_rdata_i  = 32'hBAD0BAD0;
                end
                if (c == v.gnt_dly) begin
                    dbus_gnt_i = 1'b1;
                    if (!v.exp_we && v.rv_dly == 0) begin
                        dbus_rvalid_i = 1'b1;
                        dbus_rdata_i  = v.rdata;
                    end
                end
                tick();
                dbus_gnt_i    = 1'b0;
                dbus_rvalid_i = 1'b0;
                dbus_rdata_i  = 32'h0;
            end
            if (!v.exp_we && v.rv_dly > 0) begin
                for (int c = 1; c <= v.rv_dly; c++) begin
                    if (c == 1) chk($sformatf("v%0d_req_drop", idx), 32'(dbus_req_o), 32'd0);
                    if (c == v.rv_dly) begin
                        dbus_rvalid_i = 1'b1;
                        dbus_rdata_i  = v.rdata;
                    end
                    tick();
                    dbus_rvalid_i = 1'b0;
                    dbus_rdata_i  = 32'h0;
                end
            end
        end else begin
            chk($sformatf("v%0d_no_dbus_req", idx), 32'(dbus_req_o), 32'd0);
        end
        guard = 0;
        while (!wb_seen && guard < 10) begin
            tick();
            guard++;
        end
        chk($sformatf("v%0d_wb_seen", idx), 32'(wb_seen), 32'd1);
        chk($sformatf("v%0d_ready_after", idx), 32'(req_ready_o), 32'd1);
        tick();
    endtask

    // Entry that never completes on the bus must fault after TO cycles busy
    task automatic timeout_seq(input aluop_t op, input bit give_gnt, input string tag);
        wb_exp_t e;
        int busy;
        int guard;
        busy = 0;
        guard = 0;
        wb_seen      = 1'b0;
        req_valid_i  = 1'b1;
        aluop_i      = op;
        mem_addr_i   = 32'h300;
        store_data_i = 32'h01234567;
        reg_waddr_i  = 5'd9;
        e.rd = 5'd0; e.data = 32'd0; e.mis = 1'b0; e.fault = 1'b1;
        sb_q.push_back(e);
        tick();
        req_valid_i = 1'b0;
        if (give_gnt) dbus_gnt_i = 1'b1;
        while (!wb_seen && guard < 40) begin
            if (!req_ready_o) busy++;
            tick();
            dbus_gnt_i = 1'b0;
            guard++;
        end
        chk({tag, "_wb_seen"}, 32'(wb_seen), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy), 32'(TO));
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'h55555555;
        tick();
        tick();
        dbus_rvalid_i = 1'b0;
        chk({tag, "_late_rvalid_no_wb"}, 32'(wb_valid_o), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    // Reset while a load is outstanding, then make sure stragglers are ignored
    task automatic reset_seq(input bit in_wait, input string tag);
        req_valid_i = 1'b1;
        aluop_i     = OP_LW;
        mem_addr_i  = 32'h400;
        reg_waddr_i = 5'd4;
        tick();
        req_valid_i = 1'b0;
        if (in_wait) begin
            dbus_gnt_i = 1'b1;
            tick();
            dbus_gnt_i = 1'b0;
            chk({tag, "_in_wait_busy"}, 32'(req_ready_o), 32'd0);
        end else begin
            chk({tag, "_req_high"}, 32'(dbus_req_o), 32'd1);
        end
        rst_i = 1'b1;
        #1;
        chk({tag, "_req_drop"}, 32'(dbus_req_o), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        #2;
        rst_i = 1'b0;
        dbus_gnt_i    = 1'b1;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'h77777777;
        tick();
        tick();
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        chk({tag, "_no_wb"}, 32'(wb_valid_o), 32'd0);
        chk({tag, "_no_req"}, 32'(dbus_req_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        vec_t add3;
        //          op      addr        sdata         rd     alu           rdata         g  r  req   we    baddr       be       bwdata        erd    edata         mis
        vecs[0]  = '{OP_SW,  32'h100, 32'hDEADBEEF, 5'd1,  32'h0,        32'h0,        2, 0, 1'b1, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 5'd0,  32'h0,        1'b0};
        vecs[1]  = '{OP_SB,  32'h103, 32'h000000A5, 5'd2,  32'h0,        32'h0,        0, 0, 1'b1, 1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5, 5'd0,  32'h0,        1'b0};
        vecs[2]  = '{OP_SH,  32'h102, 32'h1234BEEF, 5'd2,  32'h0,        32'h0,        1, 0, 1'b1, 1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF, 5'd0,  32'h0,        1'b0};
        vecs[3]  = '{OP_SB,  32'h101, 32'h0000005A, 5'd2,  32'h0,        32'h0,        0, 0, 1'b1, 1'b1, 32'h100, 4'b0010, 32'h5A5A5A5A, 5'd0,  32'h0,        1'b0};
        vecs[4]  = '{OP_LB,  32'h102, 32'h0,        5'd5,  32'h0,        32'h12F45678, 0, 0, 1'b1, 1'b0, 32'h100, 4'b1111, 32'h0,        5'd5,  32'hFFFFFFF4, 1'b0};
        vecs[5]  = '{OP_LBU, 32'h102, 32'h0,        5'd5,  32'h0,        32'h12F45678, 1, 1, 1'b1, 1'b0, 32'h100, 4'b1111, 32'h0,        5'd5,  32'h000000F4, 1'b0};
        vecs[6]  = '{OP_LH,  32'h102, 32'h0,        5'd5,  32'h0,        32'h12F45678, 0, 2, 1'b1, 1'b0, 32'h100, 4'b1111, 32'h0,        5'd5,  32'h000012F4, 1'b0};
        vecs[7]  = '{OP_LHU, 32'h200, 32'h0,        5'd6,  32'h0,        32'h00009ABC, 0, 0, 1'b1, 1'b0, 32'h200, 4'b1111, 32'h0,        5'd6,  32'h00009ABC, 1'b0};
        vecs[8]  = '{OP_LH,  32'h200, 32'h0,        5'd6,  32'h0,        32'h00009ABC, 2, 0, 1'b1, 1'b0, 32'h200, 4'b1111, 32'h0,        5'd6,  32'hFFFF9ABC, 1'b0};
        vecs[9]  = '{OP_LW,  32'h104, 32'h0,        5'd7,  32'h0,        32'h12F45678, 0, 1, 1'b1, 1'b0, 32'h104, 4'b1111, 32'h0,        5'd7,  32'h12F45678, 1'b0};
        vecs[10] = '{OP_LB,  32'h103, 32'h0,        5'd8,  32'h0,        32'h82F45678, 0, 0, 1'b1, 1'b0, 32'h100, 4'b1111, 32'h0,        5'd8,  32'hFFFFFF82, 1'b0};
        vecs[11] = '{OP_LBU, 32'h100, 32'h0,        5'd8,  32'h0,        32'h12F45678, 0, 0, 1'b1, 1'b0, 32'h100, 4'b1111, 32'h0,        5'd8,  32'h00000078, 1'b0};
        vecs[12] = '{OP_LW,  32'h102, 32'h0,        5'd9,  32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        5'd0,  32'h0,        1'b1};
        vecs[13] = '{OP_LH,  32'h101, 32'h0,        5'd9,  32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        5'd0,  32'h0,        1'b1};
        vecs[14] = '{OP_SW,  32'h101, 32'h11111111, 5'd9,  32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        5'd0,  32'h0,        1'b1};
        vecs[15] = '{TB_OP_ADD, 32'h3, 32'h0,       5'd7,  32'h11223344, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        5'd7,  32'h11223344, 1'b0};
        vecs[16] = '{OP_SW,  32'h010, 32'h0F0F0F0F, 5'd1,  32'h0,        32'h0,        7, 0, 1'b1, 1'b1, 32'h010, 4'b1111, 32'h0F0F0F0F, 5'd0,  32'h0,        1'b0};
        vecs[17] = '{OP_LW,  32'h020, 32'h0,        5'd10, 32'h0,        32'hCAFEF00D, 0, 7, 1'b1, 1'b0, 32'h020, 4'b1111, 32'h0,        5'd10, 32'hCAFEF00D, 1'b0};
        vecs[18] = '{OP_SH,  32'h100, 32'h0000CAFE, 5'd3,  32'h0,        32'h0,        0, 0, 1'b1, 1'b1, 32'h100, 4'b0011, 32'hCAFECAFE, 5'd0,  32'h0,        1'b0};

        #2 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_dbus_req", 32'(dbus_req_o), 32'd0);
        chk("rst_dbus_addr", dbus_addr_o, 32'd0);
        chk("rst_dbus_be", 32'(dbus_be_o), 32'd0);
        chk("rst_reg_waddr", 32'(reg_waddr_o), 32'd0);
        chk("rst_reg_wdata", reg_wdata_o, 32'd0);
        chk("rst_exc", 32'({exc_misalign_o, exc_fault_o}), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        timeout_seq(OP_LW, 1'b1, "to_load_wait");
        timeout_seq(OP_SW, 1'b0, "to_store_req");

        reset_seq(1'b0, "rst_in_req");
        reset_seq(1'b1, "rst_in_wait");
        add3 = '{TB_OP_ADD, 32'h0, 32'h0, 5'd3, 32'hA0B0C0D0, 32'h0, 0, 0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 5'd3, 32'hA0B0C0D0, 1'b0};
        run_vec(add3, 99);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
